seg_pipe_adder: RTL



---
 rtl/seg_pipe_adder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder
//   Segmented, pipelined adder/subtractor. Each pipeline stage resolves one
//   SEG_W-bit ripple segment; the segment carry is registered between stages.
//   Results leave through a valid/ready handshake with backpressure.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand bundle handshake (in_ready is combinational)
//   a, b, cin, sub      operands; sub=1 computes a - b and ignores cin
//   out_valid/out_ready result handshake
//   sum, cout, ovf      result, MSB carry-out (SUB: 1 = no borrow), signed overflow
module seg_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8,
  parameter int NSEG  = WIDTH / SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (WIDTH % SEG_W != 0) begin : g_bad_seg
    $error("seg_pipe_adder: WIDTH must be a multiple of SEG_W");
  end
  if (NSEG != WIDTH / SEG_W) begin : g_bad_nseg
    $error("seg_pipe_adder: NSEG is derived from WIDTH/SEG_W and must not be overridden");
  end

  // Per-stage register views, indexed by stage (0 = first stage).
  logic [NSEG-1:0]  w_vld;
  logic [NSEG:0]    w_rdy;
  logic [NSEG-1:0]  w_c_st;
  logic [WIDTH-1:0] w_a_st [NSEG];
  logic [WIDTH-1:0] w_b_st [NSEG];
  logic [WIDTH-1:0] w_s_st [NSEG];
  logic             w_cmsb;
  logic [WIDTH-1:0] w_b_in;

  // Subtraction is a + ~b + 1: b is inverted once at entry and the +1 enters
  // as the first-stage carry.
  assign w_b_in = sub ? ~b : b;

  // Ready chain: a stage can load if it is empty or the next one is loading.
  always_comb begin
    w_rdy       = '0;
    w_rdy[NSEG] = out_ready;
    for (int i = NSEG - 1; i >= 0; i--) begin
      w_rdy[i] = !w_vld[i] || w_rdy[i+1];
    end
  end

  for (genvar i = 0; i < NSEG; i++) begin : g_stage
    logic             w_up_vld;
    logic [WIDTH-1:0] w_up_a;
    logic [WIDTH-1:0] w_up_b;
    logic [WIDTH-1:0] w_up_s;
    logic             w_up_c;
    logic [SEG_W-1:0] w_seg_a;
    logic [SEG_W-1:0] w_seg_b;
    logic [SEG_W-1:0] w_seg_s;
    logic [SEG_W:0]   w_carry;
    logic [WIDTH-1:0] w_next_s;

    logic             r_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;

    if (i == 0) begin : g_first
      assign w_up_vld = in_valid;
      assign w_up_a   = a;
      assign w_up_b   = w_b_in;
      assign w_up_c   = sub | cin;
      assign w_up_s   = '0;
    end else begin : g_next
      assign w_up_vld = w_vld[i-1];
      assign w_up_a   = w_a_st[i-1];
      assign w_up_b   = w_b_st[i-1];
      assign w_up_c   = w_c_st[i-1];
      assign w_up_s   = w_s_st[i-1];
    end

    assign w_seg_a = w_up_a[i*SEG_W +: SEG_W];
    assign w_seg_b = w_up_b[i*SEG_W +: SEG_W];

    // Ripple of majority carry cells with XOR sum cells.
    always_comb begin
      w_carry    = '0;
      w_seg_s    = '0;
      w_carry[0] = w_up_c;
      for (int k = 0; k < SEG_W; k++) begin
        w_seg_s[k]   = w_seg_a[k] ^ w_seg_b[k] ^ w_carry[k];
        w_carry[k+1] = (w_seg_a[k] & w_seg_b[k]) | (w_carry[k] & (w_seg_a[k] | w_seg_b[k]));
      end
    end

    always_comb begin
      w_next_s                    = w_up_s;
      w_next_s[i*SEG_W +: SEG_W]  = w_seg_s;
    end

    // Data registers load only with a real transaction so idle cycles do not toggle them.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_a     <= '0;
        r_b     <= '0;
        r_sum   <= '0;
        r_c     <= 1'b0;
      end else begin
        if (w_rdy[i]) begin
          r_valid <= w_up_vld;
        end
        if (w_rdy[i] && w_up_vld) begin
          r_a   <= w_up_a;
          r_b   <= w_up_b;
          r_sum <= w_next_s;
          r_c   <= w_carry[SEG_W];
        end
      end
    end

    assign w_vld[i]  = r_valid;
    assign w_a_st[i] = r_a;
    assign w_b_st[i] = r_b;
    assign w_s_st[i] = r_sum;
    assign w_c_st[i] = r_c;

    // Carry into the MSB is only needed for overflow, which the last stage resolves.
    if (i == NSEG - 1) begin : g_msb
      logic r_cmsb;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cmsb <= 1'b0;
        end else if (w_rdy[i] && w_up_vld) begin
          r_cmsb <= w_carry[SEG_W-1];
        end
      end
      assign w_cmsb = r_cmsb;
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = w_vld[NSEG-1];
  assign sum       = w_s_st[NSEG-1];
  assign cout      = w_c_st[NSEG-1];
  assign ovf       = w_cmsb ^ w_c_st[NSEG-1];

endmodule
